// File: rtl/fetch_pc_seq.sv
// fetch_pc_seq: program-counter sequencer for the instruction-fetch stage.
// It supports relative branches, absolute jumps, call/return through a return-address
// stack, stall, halt and auto-halt at HALT_PC.
// Optional macro PC_BOUND_CHECK_EN: when defined, any computed next PC above PC_LIMIT
// halts the sequencer and sets the sticky bound_err flag.
module fetch_pc_seq #(
  parameter int              PC_W      = 10,
  parameter int              OFF_W     = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] HALT_PC   = {PC_W{1'b1}},
  parameter logic [PC_W-1:0] PC_LIMIT  = {PC_W{1'b1}}
) (
  input  logic             CLK,
  input  logic             init,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_en,
  input  logic             bSIGN,
  input  logic [OFF_W-1:0] bOFFSET,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [PC_W-1:0]  jump_addr,
  output logic [PC_W-1:0]  PC,
  output logic             running,
  output logic             done,
  output logic             ras_err,
  output logic             bound_err
);

  localparam int CW = $clog2(RAS_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t                            state_q, state_d;
  logic [PC_W-1:0]                   pc_q, pc_d;
  logic [RAS_DEPTH-1:0][PC_W-1:0]    ras_q, ras_d;
  logic [CW-1:0]                     cnt_q, cnt_d;
  logic                              ras_err_q, ras_err_d;
  logic                              bound_err_q, bound_err_d;

  logic [PC_W-1:0] pc_inc, ras_top, tgt;
  logic            move, push, pop;

  assign pc_inc = pc_q + PC_W'(1);

  // Top-of-stack read: entry cnt_q-1 (don't care when empty).
  always_comb begin
    ras_top = '0;
    for (int i = 0; i < RAS_DEPTH; i++)
      if (cnt_q == CW'(i + 1)) ras_top = ras_q[i];
  end

  // Next-state / next-PC: start overrides all; in RUN one prioritised action per cycle.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ras_d       = ras_q;
    cnt_d       = cnt_q;
    ras_err_d   = ras_err_q;
    bound_err_d = bound_err_q;
    tgt         = pc_inc;
    move        = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    if (start) begin
      pc_d        = start_addr;
      state_d     = S_RUN;
      cnt_d       = '0;
      ras_err_d   = 1'b0;
      bound_err_d = 1'b0;
    end else if (state_q == S_RUN) begin
      if (halt) begin
        state_d = S_HALTED;
      end else if (stall) begin
        state_d = S_RUN;
      end else if (pc_q == HALT_PC) begin
        state_d = S_HALTED;
      end else if (ret_en) begin
        if (cnt_q == '0) begin
          ras_err_d = 1'b1;
          state_d   = S_HALTED;
        end else begin
          tgt  = ras_top;
          pop  = 1'b1;
          move = 1'b1;
        end
      end else if (call_en) begin
        if (cnt_q == CW'(RAS_DEPTH)) begin
          ras_err_d = 1'b1;
          state_d   = S_HALTED;
        end else begin
          tgt  = jump_addr;
          push = 1'b1;
          move = 1'b1;
        end
      end else if (jump_en) begin
        tgt  = jump_addr;
        move = 1'b1;
      end else if (branch_en) begin
        tgt  = bSIGN ? pc_q - PC_W'(bOFFSET) : pc_q + PC_W'(bOFFSET);
        move = 1'b1;
      end else begin
        tgt  = pc_inc;
        move = 1'b1;
      end

`ifdef PC_BOUND_CHECK_EN
      // Out-of-range target: stop in place, leave the stack untouched.
      if (move && (tgt > PC_LIMIT)) begin
        bound_err_d = 1'b1;
        state_d     = S_HALTED;
        move        = 1'b0;
      end
`endif

      if (move) begin
        pc_d = tgt;
        if (pop) cnt_d = cnt_q - CW'(1);
        if (push) begin
          for (int i = 0; i < RAS_DEPTH; i++)
            if (cnt_q == CW'(i)) ras_d[i] = pc_inc;
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge init) begin
    if (init) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      ras_q       <= '0;
      cnt_q       <= '0;
      ras_err_q   <= 1'b0;
      bound_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ras_q       <= ras_d;
      cnt_q       <= cnt_d;
      ras_err_q   <= ras_err_d;
      bound_err_q <= bound_err_d;
    end
  end

  assign PC      = pc_q;
  assign running = (state_q == S_RUN);
  assign done    = (state_q == S_HALTED);
  assign ras_err = ras_err_q;

`ifdef PC_BOUND_CHECK_EN
  assign bound_err = bound_err_q;
`else
  // Without the check the flag register never sets; the output is a hard zero.
  logic unused_bound;
  assign unused_bound = bound_err_q ^ (^PC_LIMIT);
  assign bound_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Self-checking bench for fetch_pc_seq: vector table, hand-written corner sequences,
// and randomized stimulus against a queue-based reference model.
module tb_fetch_pc_seq;
  localparam int PC_W = 10, OFF_W = 8, RAS_D = 4;
  localparam int HALT = 50, LIMIT = 100, MOD = 1024;

  logic             CLK = 0, init = 1;
  logic             start = 0, stall = 0, halt = 0, branch_en = 0, bSIGN = 0;
  logic             jump_en = 0, call_en = 0, ret_en = 0;
  logic [PC_W-1:0]  start_addr = '0, jump_addr = '0;
  logic [OFF_W-1:0] bOFFSET = '0;
  logic [PC_W-1:0]  PC;
  logic             running, done, ras_err, bound_err;

  fetch_pc_seq #(.PC_W(PC_W), .OFF_W(OFF_W), .RAS_DEPTH(RAS_D),
                 .HALT_PC(10'd50), .PC_LIMIT(10'd100)) dut (
    .CLK(CLK), .init(init), .start(start), .start_addr(start_addr), .stall(stall),
    .halt(halt), .branch_en(branch_en), .bSIGN(bSIGN), .bOFFSET(bOFFSET),
    .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .jump_addr(jump_addr),
    .PC(PC), .running(running), .done(done), .ras_err(ras_err), .bound_err(bound_err));

  always #5 CLK = ~CLK;

  int n_chk = 0, n_fail = 0;

  // Reference model: mode 0 idle, 1 run, 2 halted.
  int m_mode, m_pc;
  int m_ras[$];
  bit m_rerr, m_berr;

  function automatic void m_reset();
    m_mode = 0; m_pc = 0; m_ras.delete(); m_rerr = 0; m_berr = 0;
  endfunction

  function automatic void m_step();
    int t; bit mv, psh, pp;
    mv = 0; psh = 0; pp = 0; t = 0;
    if (start) begin
      m_pc = int'(start_addr); m_mode = 1; m_ras.delete(); m_rerr = 0; m_berr = 0;
    end else if (m_mode == 1) begin
      if (halt) m_mode = 2;
      else if (stall) ;
      else if (m_pc == HALT) m_mode = 2;
      else if (ret_en) begin
        if (m_ras.size() == 0) begin m_rerr = 1; m_mode = 2; end
        else begin t = m_ras[m_ras.size()-1]; pp = 1; mv = 1; end
      end else if (call_en) begin
        if (m_ras.size() == RAS_D) begin m_rerr = 1; m_mode = 2; end
        else begin t = int'(jump_addr); psh = 1; mv = 1; end
      end else if (jump_en) begin t = int'(jump_addr); mv = 1; end
      else if (branch_en) begin
        t = bSIGN ? (m_pc - int'(bOFFSET) + MOD) % MOD : (m_pc + int'(bOFFSET)) % MOD;
        mv = 1;
      end else begin t = (m_pc + 1) % MOD; mv = 1; end
`ifdef PC_BOUND_CHECK_EN
      if (mv && t > LIMIT) begin m_berr = 1; m_mode = 2; mv = 0; end
`endif
      if (mv) begin
        if (pp) void'(m_ras.pop_back());
        if (psh) m_ras.push_back((m_pc + 1) % MOD);
        m_pc = t;
      end
    end
  endfunction

  task automatic chk(string nm, int e_pc, bit e_run, bit e_done, bit e_rerr, bit e_berr);
    n_chk++;
    if (PC !== e_pc[PC_W-1:0] || running !== e_run || done !== e_done ||
        ras_err !== e_rerr || bound_err !== e_berr) begin
      n_fail++;
      $display("FAIL %s: got pc=%0d run=%b done=%b rerr=%b berr=%b, want pc=%0d run=%b done=%b rerr=%b berr=%b",
               nm, PC, running, done, ras_err, bound_err, e_pc, e_run, e_done, e_rerr, e_berr);
    end
  endtask

  task automatic chk_model(string nm);
    chk(nm, m_pc, m_mode == 1, m_mode == 2, m_rerr, m_berr);
  endtask

  task automatic clr();
    start = 0; stall = 0; halt = 0; branch_en = 0; bSIGN = 0; bOFFSET = '0;
    jump_en = 0; call_en = 0; ret_en = 0; start_addr = '0; jump_addr = '0;
  endtask

  // Advance the model with the current inputs, then let the DUT take the edge.
  task automatic cyc();
    m_step();
    @(posedge CLK); #1;
  endtask

  typedef struct {
    bit st; int sa; bit stl, hlt, br, sg; int off; bit jmp, cl, rt; int ja;
    int e_pc; bit e_run, e_done, e_rerr;
  } vec_t;

  function automatic vec_t v(bit st, int sa, bit stl, bit hlt, bit br, bit sg, int off,
                             bit jmp, bit cl, bit rt, int ja,
                             int e_pc, bit e_run, bit e_done, bit e_rerr);
    vec_t r;
    r.st = st; r.sa = sa; r.stl = stl; r.hlt = hlt; r.br = br; r.sg = sg; r.off = off;
    r.jmp = jmp; r.cl = cl; r.rt = rt; r.ja = ja;
    r.e_pc = e_pc; r.e_run = e_run; r.e_done = e_done; r.e_rerr = e_rerr;
    return r;
  endfunction

  vec_t tbl[32];

  initial begin
    //          st sa  stl hl br sg off jm cl rt ja    pc run dn re
    tbl[0]  = v(1, 2,  0,0,0,0,0, 0,0,0,0,  2, 1,0,0);
    tbl[1]  = v(0, 0,  0,0,0,0,0, 0,0,0,0,  3, 1,0,0);
    tbl[2]  = v(0, 0,  0,0,0,0,0, 0,0,0,0,  4, 1,0,0);
    tbl[3]  = v(0, 0,  0,0,0,0,0, 0,0,0,0,  5, 1,0,0);
    tbl[4]  = v(0, 0,  0,0,0,0,0, 1,0,0,20, 20,1,0,0);
    tbl[5]  = v(0, 0,  0,0,1,1,5, 0,0,0,0,  15,1,0,0);
    tbl[6]  = v(0, 0,  0,0,1,0,8, 0,0,0,0,  23,1,0,0);
    tbl[7]  = v(0, 0,  0,0,0,0,0, 1,0,0,10, 10,1,0,0);
    tbl[8]  = v(0, 0,  0,0,0,0,0, 0,1,0,40, 40,1,0,0);
    tbl[9]  = v(0, 0,  0,0,0,0,0, 0,0,1,0,  11,1,0,0);
    tbl[10] = v(0, 0,  0,0,0,0,0, 0,0,1,0,  11,0,1,1);
    tbl[11] = v(1, 12, 0,0,0,0,0, 0,0,0,0,  12,1,0,0);
    tbl[12] = v(0, 0,  0,0,0,0,0, 0,1,0,30, 30,1,0,0);
    tbl[13] = v(0, 0,  0,0,0,0,0, 0,1,0,31, 31,1,0,0);
    tbl[14] = v(0, 0,  0,0,0,0,0, 0,1,0,32, 32,1,0,0);
    tbl[15] = v(0, 0,  0,0,0,0,0, 0,1,0,33, 33,1,0,0);
    tbl[16] = v(0, 0,  0,0,0,0,0, 0,1,0,34, 33,0,1,1);
    tbl[17] = v(1, 45, 0,0,0,0,0, 0,0,0,0,  45,1,0,0);
    tbl[18] = v(0, 0,  0,0,0,0,0, 0,0,0,0,  46,1,0,0);
    tbl[19] = v(0, 0,  0,0,0,0,0, 0,0,0,0,  47,1,0,0);
    tbl[20] = v(0, 0,  0,0,0,0,0, 0,0,0,0,  48,1,0,0);
    tbl[21] = v(0, 0,  0,0,0,0,0, 0,0,0,0,  49,1,0,0);
    tbl[22] = v(0, 0,  0,0,0,0,0, 0,0,0,0,  50,1,0,0);
    tbl[23] = v(0, 0,  0,0,0,0,0, 0,0,0,0,  50,0,1,0);
    tbl[24] = v(0, 0,  0,0,0,0,0, 1,0,0,9,  50,0,1,0);
    tbl[25] = v(1, 0,  0,0,0,0,0, 0,0,0,0,  0, 1,0,0);
    tbl[26] = v(0, 0,  0,0,0,0,0, 1,0,0,7,  7, 1,0,0);
    tbl[27] = v(0, 0,  1,0,1,0,9, 0,0,0,0,  7, 1,0,0);
    tbl[28] = v(0, 0,  1,0,1,0,9, 0,0,0,0,  7, 1,0,0);
    tbl[29] = v(0, 0,  1,0,1,0,9, 0,0,0,0,  7, 1,0,0);
    tbl[30] = v(0, 0,  1,1,0,0,0, 0,0,0,0,  7, 0,1,0);
    tbl[31] = v(0, 0,  0,0,0,0,0, 1,0,0,9,  7, 0,1,0);

    m_reset();
    #2 chk("reset", 0, 0, 0, 0, 0);
    @(negedge CLK); init = 0;
    @(posedge CLK); #1;
    chk("idle_after_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 32; i++) begin
      start = tbl[i].st; start_addr = tbl[i].sa[PC_W-1:0];
      stall = tbl[i].stl; halt = tbl[i].hlt; branch_en = tbl[i].br; bSIGN = tbl[i].sg;
      bOFFSET = tbl[i].off[OFF_W-1:0]; jump_en = tbl[i].jmp; call_en = tbl[i].cl;
      ret_en = tbl[i].rt; jump_addr = tbl[i].ja[PC_W-1:0];
      cyc();
      chk($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_run, tbl[i].e_done, tbl[i].e_rerr, 1'b0);
    end
    clr();

`ifdef PC_BOUND_CHECK_EN
    start = 1; start_addr = 30; cyc(); start = 0;
    chk("bnd_start", 30, 1, 0, 0, 0);
    jump_en = 1; jump_addr = 150; cyc(); clr();
    chk("bnd_jump", 30, 0, 1, 0, 1);
    start = 1; start_addr = 2; cyc(); clr();
    chk("bnd_clear", 2, 1, 0, 0, 0);
`else
    start = 1; start_addr = 1021; cyc(); start = 0;
    chk("wrap_start", 1021, 1, 0, 0, 0);
    cyc(); chk("wrap_1022", 1022, 1, 0, 0, 0);
    cyc(); chk("wrap_1023", 1023, 1, 0, 0, 0);
    cyc(); chk("wrap_0", 0, 1, 0, 0, 0);
    branch_en = 1; bSIGN = 1; bOFFSET = 3; cyc(); clr();
    chk("wrap_back", 1021, 1, 0, 0, 0);
    jump_en = 1; jump_addr = 1023; cyc(); clr();
    call_en = 1; jump_addr = 5; cyc(); clr();
    chk("call_at_top", 5, 1, 0, 0, 0);
    ret_en = 1; cyc(); clr();
    chk("ret_wrapped", 0, 1, 0, 0, 0);
`endif

    // Asynchronous reset between edges.
    start = 1; start_addr = 5; cyc(); start = 0;
    cyc(); chk("pre_init", 6, 1, 0, 0, 0);
    #3 init = 1;
    #1 chk("init_async", 0, 0, 0, 0, 0);
    m_reset();
    #1 init = 0;
    jump_en = 1; jump_addr = 9; cyc(); clr();
    chk("idle_ignores", 0, 0, 0, 0, 0);

    // Randomized run against the model.
    for (int i = 0; i < 800; i++) begin
      start      = ($urandom % 24) == 0;
      start_addr = (($urandom % 8) == 0) ? PC_W'($urandom % MOD) : PC_W'($urandom % 64);
      stall      = ($urandom % 6) == 0;
      halt       = ($urandom % 50) == 0;
      branch_en  = ($urandom % 4) == 0;
      bSIGN      = $urandom % 2;
      bOFFSET    = OFF_W'($urandom % 20);
      jump_en    = ($urandom % 8) == 0;
      call_en    = ($urandom % 6) == 0;
      ret_en     = ($urandom % 6) == 0;
      jump_addr  = (($urandom % 10) == 0) ? PC_W'($urandom % MOD) : PC_W'($urandom % 64);
      cyc();
      chk_model($sformatf("rand%0d", i));
    end
    clr();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_pc_seq.md
Name: fetch_pc_seq

Overview:
Parametrised program-counter sequencer for the instruction-fetch stage. It supports:
- externally supplied program start addresses,
- sign/magnitude relative branches,
- absolute jumps,
- call/return through a hardware return-address stack (RAS),
- stall, explicit halt, and auto-halt at a configurable end address.

It drives the instruction-ROM address and reports run/done status to the top-level test harness.

Parameters:
PC_W, 10, PC and address width in bits
OFF_W, 8, branch offset magnitude width (offset is zero-extended to PC_W)
RAS_DEPTH, 4, return-address stack entries (>=1)
HALT_PC, 10'h3FF, PC value at which the sequencer auto-halts
PC_LIMIT, 10'h3FF, highest legal PC (used only with PC_BOUND_CHECK_EN)

Ports:
CLK  input  1  clock, rising edge
init  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse: load start_addr and run
start_addr  input  PC_W  program entry address
stall  input  1  hold PC and RAS this cycle
halt  input  1  explicit stop request
branch_en  input  1  relative branch taken
bSIGN  input  1  1 = backward (PC - bOFFSET), 0 = forward (PC + bOFFSET)
bOFFSET  input  OFF_W  branch magnitude
jump_en  input  1  absolute jump to jump_addr
call_en  input  1  push PC+1, go to jump_addr
ret_en  input  1  pop RAS into PC
jump_addr  input  PC_W  jump/call target
PC  output  PC_W  current fetch address
running  output  1  1 while in RUN
done  output  1  1 while in HALTED
ras_err  output  1  sticky RAS overflow/underflow flag
bound_err  output  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- States: IDLE, RUN, HALTED. running = (state==RUN); done = (state==HALTED). Both are registered-state decodes.
- Reset (init=1, async): PC=0, state=IDLE, RAS empty (count=0), ras_err=0, bound_err=0. Reset mid-run discards all state immediately.
- start, in any state, has priority over everything else except reset:
  - PC<=start_addr, state<=RUN.
  - RAS cleared, ras_err and bound_err cleared.
- IDLE and HALTED: PC holds; all inputs other than start are ignored.
- RUN: one action per cycle, in priority order:
  1. halt -> HALTED, PC holds.
  2. stall -> hold everything.
  3. PC==HALT_PC -> HALTED, PC holds. The instruction at HALT_PC is fetched exactly once.
  4. ret_en:
     - RAS empty -> ras_err<=1, HALTED, PC holds.
     - otherwise -> PC<=top, pop.
  5. call_en:
     - RAS full -> ras_err<=1, HALTED, PC holds.
     - otherwise -> push PC+1, PC<=jump_addr.
  6. jump_en -> PC<=jump_addr.
  7. branch_en -> PC<=PC-bOFFSET if bSIGN, else PC+bOFFSET.
  8. default -> PC<=PC+1.
- Arithmetic: all PC math is modulo 2^PC_W (wrap-around, no saturation). A pushed return address of all-ones wraps to 0.
- RAS behaviour:
  - LIFO, depth RAS_DEPTH.
  - Push and pop never occur in the same cycle (priority resolves it).
  - Contents are not visible on ports.
- Latency: every control input takes effect on PC at the next rising CLK. There is no combinational path from inputs to PC.

Optional Feature:
- Macro: PC_BOUND_CHECK_EN.
- With it defined: in RUN, if the computed next PC (jump, call, ret, branch or increment) > PC_LIMIT:
  - bound_err<=1 (sticky),
  - state<=HALTED,
  - PC holds its current value,
  - the RAS is unchanged.
- Without it: no check is performed, targets wrap modulo 2^PC_W, and bound_err is tied to 0.

Test Plan:
- Reset, then start with start_addr=2 -> PC=2 and running=1 next cycle; PC=3,4,5 on successive cycles.
- PC=20, branch_en=1, bSIGN=1, bOFFSET=5 -> PC=15. Then bSIGN=0, bOFFSET=8 -> PC=23. Then PC=1023, increment -> PC=0 (wrap, macro undefined).
- call_en at PC=10 with jump_addr=40 -> PC=40; ret_en -> PC=11. Five nested calls with RAS_DEPTH=4 -> ras_err=1, done=1, PC holds at the 4th target.
- HALT_PC=50, run from 45 -> PC reaches 50, then done=1 and PC stays 50 indefinitely. start_addr=0 with start -> PC=0, running=1, ras_err=0.
- stall asserted for 3 cycles at PC=7 with branch_en=1 -> PC holds 7. halt with stall -> HALTED. init asserted mid-run between edges -> PC=0 and running=0 immediately.
- PC_BOUND_CHECK_EN defined, PC_LIMIT=100: jump_en to 150 at PC=30 -> bound_err=1, done=1, PC=30.
